// File: rtl/reg_read_stage_pkg.sv
// ---------------------------------------------------------------------------
// reg_read_stage_pkg
// Shared definitions for the decode/register-read stage of the R-type
// datapath: data and register-address widths, instruction field positions,
// the R-type opcode, the supported funct codes, and a helper that decides
// whether an instruction word is a supported R-type.
// ---------------------------------------------------------------------------
package reg_read_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Instruction field positions (least significant bit of each field)
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;

    localparam int OPCODE_W = 6;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;

    localparam logic [OPCODE_W-1:0] OPCODE_RTYPE = 6'b000000;

    typedef enum logic [FUNCT_W-1:0] {
        FUNCT_ADDU = 6'b001001,
        FUNCT_SUBU = 6'b001010,
        FUNCT_SLL  = 6'b100001,
        FUNCT_SLLV = 6'b110101
    } funct_e;

    // True only for an R-type opcode carrying one of the supported funct codes
    function automatic logic is_supported_rtype(
        input logic [OPCODE_W-1:0] opcode,
        input logic [FUNCT_W-1:0]  funct
    );
        logic funct_ok;
        funct_ok = 1'b0;
        case (funct)
            FUNCT_ADDU, FUNCT_SUBU, FUNCT_SLL, FUNCT_SLLV: funct_ok = 1'b1;
            default:                                       funct_ok = 1'b0;
        endcase
        return (opcode == OPCODE_RTYPE) && funct_ok;
    endfunction

endpackage

// File: rtl/reg_read_stage_if.sv
// ---------------------------------------------------------------------------
// reg_read_stage_if
// Bundles every handshake and bus signal of the register-read stage.
//   Upstream:  in_valid, in_ready, instr
//   Writeback: wb_en, wb_addr, wb_data
//   To ALU:    out_valid, out_ready, Rs_data, Rt_data, shamt, funct,
//              rd_addr, illegal
// Modports:
//   slave  - the register-read stage itself
//   master - the environment (fetch, writeback and ALU side)
// ---------------------------------------------------------------------------
interface reg_read_stage_if;
    import reg_read_stage_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   instr;

    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   Rs_data;
    logic [DATA_W-1:0]   Rt_data;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [ADDR_W-1:0]   rd_addr;
    logic                illegal;

    modport slave (
        input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, Rs_data, Rt_data, shamt, funct,
               rd_addr, illegal
    );

    modport master (
        output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, Rs_data, Rt_data, shamt, funct,
               rd_addr, illegal
    );

endinterface

// File: rtl/reg_read_stage_reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 32 x 32-bit register file with two combinational read ports and one
// synchronous write port. Register 0 always reads zero and ignores writes.
// A synchronous active-low reset clears every register.
// Ports:
//   clk, rst_n              clock, synchronous active-low clear
//   rd_addr_a / rd_data_a   read port A (combinational)
//   rd_addr_b / rd_data_b   read port B (combinational)
//   wr_en, wr_addr, wr_data write port, takes effect at the rising edge
// ---------------------------------------------------------------------------
module reg_file
    import reg_read_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next array contents: copy the current contents, then apply the single
    // write. Writes aimed at register 0 are dropped here so it never holds
    // anything but zero.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Array storage; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports return the stored (pre-write) value; register 0 is forced
    // to zero at the read mux as well.
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/reg_read_stage.sv
// ---------------------------------------------------------------------------
// reg_read_stage
// Decode/register-read stage ahead of the ALU. Accepts an instruction over a
// valid/ready handshake, splits it into fields, reads Rs and Rt from the
// register file and captures everything into a single output slot. Also
// owns the register-file write port driven by writeback.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset (clears slot and register file)
//   bus    reg_read_stage_if.slave: upstream handshake + instr, writeback
//          port, and the output slot towards the ALU
// Configuration macro:
//   REG_BYPASS_EN  when defined, a writeback to rs/rt in the same cycle as an
//                  accept is forwarded into the captured operand
//                  (write-first). When undefined, the captured operand is the
//                  pre-write array value (read-first).
// ---------------------------------------------------------------------------
module reg_read_stage
    import reg_read_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    reg_read_stage_if.slave bus
);

    logic [OPCODE_W-1:0] opcode_field;
    logic [ADDR_W-1:0]   rs_field;
    logic [ADDR_W-1:0]   rt_field;
    logic [ADDR_W-1:0]   rd_field;
    logic [SHAMT_W-1:0]  shamt_field;
    logic [FUNCT_W-1:0]  funct_field;

    logic [DATA_W-1:0]   rf_rs_data;
    logic [DATA_W-1:0]   rf_rt_data;
    logic [DATA_W-1:0]   rs_value;
    logic [DATA_W-1:0]   rt_value;

    logic                accept;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   rs_data_q,   rs_data_d;
    logic [DATA_W-1:0]   rt_data_q,   rt_data_d;
    logic [SHAMT_W-1:0]  shamt_q,     shamt_d;
    logic [FUNCT_W-1:0]  funct_q,     funct_d;
    logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
    logic                illegal_q,   illegal_d;

    assign opcode_field = bus.instr[OPCODE_LSB +: OPCODE_W];
    assign rs_field     = bus.instr[RS_LSB     +: ADDR_W];
    assign rt_field     = bus.instr[RT_LSB     +: ADDR_W];
    assign rd_field     = bus.instr[RD_LSB     +: ADDR_W];
    assign shamt_field  = bus.instr[SHAMT_LSB  +: SHAMT_W];
    assign funct_field  = bus.instr[FUNCT_LSB  +: FUNCT_W];

    reg_file u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs_field),
        .rd_data_a (rf_rs_data),
        .rd_addr_b (rt_field),
        .rd_data_b (rf_rt_data),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_addr),
        .wr_data   (bus.wb_data)
    );

    // Operand selection. With bypass enabled a same-cycle writeback to a
    // nonzero rs/rt overrides the array value; register 0 is never bypassed
    // because writes to it never land.
`ifdef REG_BYPASS_EN
    always_comb begin
        rs_value = rf_rs_data;
        rt_value = rf_rt_data;
        if (bus.wb_en && (bus.wb_addr == rs_field) && (rs_field != '0)) begin
            rs_value = bus.wb_data;
        end
        if (bus.wb_en && (bus.wb_addr == rt_field) && (rt_field != '0)) begin
            rt_value = bus.wb_data;
        end
    end
`else
    always_comb begin
        rs_value = rf_rs_data;
        rt_value = rf_rt_data;
    end
`endif

    // The slot can take a new instruction when it is empty or being drained
    // this very cycle, which gives one instruction per cycle when the ALU
    // keeps out_ready high.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Slot next-state: load everything on accept; on a drain without a new
    // accept only out_valid drops and the data fields keep their last value.
    // While stalled nothing changes, so later register writes cannot disturb
    // the captured operands.
    always_comb begin
        out_valid_d = out_valid_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        shamt_d     = shamt_q;
        funct_d     = funct_q;
        rd_addr_d   = rd_addr_q;
        illegal_d   = illegal_q;
        if (accept) begin
            out_valid_d = 1'b1;
            rs_data_d   = rs_value;
            rt_data_d   = rt_value;
            shamt_d     = shamt_field;
            funct_d     = funct_field;
            rd_addr_d   = rd_field;
            illegal_d   = !is_supported_rtype(opcode_field, funct_field);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Slot registers; reset discards any pending instruction without a
    // handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            shamt_q     <= '0;
            funct_q     <= '0;
            rd_addr_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            shamt_q     <= shamt_d;
            funct_q     <= funct_d;
            rd_addr_q   <= rd_addr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Rs_data   = rs_data_q;
    assign bus.Rt_data   = rt_data_q;
    assign bus.shamt     = shamt_q;
    assign bus.funct     = funct_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Decode/register-read stage feeding the ALU of the R-type datapath. Accepts a 32-bit instruction through a valid/ready handshake, splits it into fields, reads Rs and Rt from a 32×32 register file and registers everything into one output slot consumed by the ALU. It also owns the register-file write port, driven by the writeback path downstream of the ALU.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register address, 32 registers.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instr is valid this cycle
- in_ready  out  1  stage can accept instr this cycle
- instr  in  32  instruction word
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write address
- wb_data  in  32  write data
- out_valid  out  1  output slot holds an instruction for the ALU
- out_ready  in  1  ALU stage consumes the slot this cycle
- Rs_data  out  32  register[rs] captured at accept
- Rt_data  out  32  register[rt] captured at accept
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- rd_addr  out  5  instr[15:11], destination for writeback
- illegal  out  1  captured instruction is not a supported R-type

## Operation
- Fields: opcode instr[31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
- Supported funct: ADDU 6'b001001, SUBU 6'b001010, SLL 6'b100001, SLLV 6'b110101. illegal = (opcode != 0) or funct not in that set. Illegal instructions still flow; fields forwarded unchanged (ALU yields 0 for unknown funct).
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept: slot loads Rs_data, Rt_data, shamt, funct, rd_addr, illegal; out_valid <= 1.
- On out_valid && out_ready without accept: out_valid <= 0; data outputs hold last value.
- While out_valid && !out_ready: all outputs stable; register writes during the stall do not update the captured Rs_data/Rt_data.
- Register file: wb_en && wb_addr != 0 writes wb_data at the edge. Register 0 always reads 0; writes to it are dropped.
- Both read ports may address the same register; both return the same value.

## Timing
- Reset (rst_n low at edge): out_valid=0, Rs_data=0, Rt_data=0, shamt=0, funct=0, rd_addr=0, illegal=0, all 32 registers = 0. wb write in a reset cycle is ignored. in_ready = 1 after reset.
- Reset mid-operation discards the slot contents without a handshake.
- Latency: instr accepted at edge N appears on outputs after edge N; one instruction per cycle sustained when out_ready held high.
- Write visible to a read captured at edge N+1 or later if written at edge N.
- Same-cycle write and accept to the same nonzero register: see Configuration.

## Configuration
- REG_BYPASS_EN defined: on accept, if wb_en && wb_addr == rs (rs != 0) Rs_data captures wb_data; same for rt/Rt_data. Write-first behaviour.
- Not defined: capture takes the pre-write array value (read-first). Array write identical in both cases.

## Structure
- Shared package: funct constants (ADDU, SUBU, SLL, SLLV), R-type opcode 6'b000000, field bit positions, data/address widths.
- One sub-module: reg_file (32×32, two combinational read ports, one synchronous write port, reg 0 hardwired zero, synchronous active-low clear). Bypass mux and handshake stay in reg_read_stage.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, all data outputs 0; read rs=5 after reset returns 0.
- Write r1=32'h0000_0003, r2=32'h0000_0005, then accept ADDU rs=1 rt=2 rd=3 → next cycle out_valid=1, Rs_data=3, Rt_data=5, funct=6'b001001, rd_addr=3, illegal=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 and a write r1=32'hFFFF_FFFF → in_ready=0, outputs unchanged; release → second instruction accepted, sees r1=32'hFFFF_FFFF.
- Same-cycle wb r4=32'hDEAD_BEEF and accept with rs=4 → Rs_data=32'hDEAD_BEEF with REG_BYPASS_EN, old value 0 without.
- Write r0=32'h1234_5678, read rs=0 rt=0 → both 0; opcode 6'b100011 or funct 6'b000000 → illegal=1, fields passed through.
- Assert rst_n=0 while out_valid=1 and out_ready=0 → next cycle out_valid=0, registers cleared.
